// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scan controller.
// Holds segment patterns (active-high, bit0=a .. bit6=g), digit-select
// encodings, the BCD clamp limit and the conversion FSM state encoding.
package seg7_pkg;

  // Segment patterns, bit0=a .. bit6=g, active-high
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Largest value representable in four BCD digits
  localparam int unsigned BCD_MAX = 9999;

  // One-hot digit selects: com[3] drives digit0 (LSD), com[0] drives digit3 (MSD)
  localparam logic [3:0] COM_DIG0 = 4'b1000;
  localparam logic [3:0] COM_DIG1 = 4'b0100;
  localparam logic [3:0] COM_DIG2 = 4'b0010;
  localparam logic [3:0] COM_DIG3 = 4'b0001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Digit index -> one-hot select
  function automatic logic [3:0] com_of(input logic [1:0] idx);
    logic [3:0] sel;
    case (idx)
      2'd0:    sel = COM_DIG0;
      2'd1:    sel = COM_DIG1;
      2'd2:    sel = COM_DIG2;
      default: sel = COM_DIG3;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD digit to 7-segment decoder; codes 10..15 give a blank digit.
// Latency: none (purely combinational).
// Backpressure: none.
// Ports: i_bcd [3:0] BCD digit in; o_seg [6:0] active-high segments (bit0=a .. bit6=g).
module seg7_bcd_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit 7-segment scan controller: serial binary->BCD (double-dabble) plus digit multiplexing.
// Latency: load at cycle N -> busy N+1..N+DATA_W+1, new digits shown from N+DATA_W+2 (+1 for output reg).
// Backpressure: load is dropped while busy (including the final DONE cycle); nothing is queued.
// Ports: clock, reset (sync, active-high); load/value capture a binary value when idle;
//   busy = conversion running; ovf = shown value was clamped to 9999;
//   com[3:0] one-hot digit select (com[3]=digit0 .. com[0]=digit3); data_out[6:0] segments (bit0=a).
// Build option: define SEG7_LZ_BLANK_EN to blank leading zero digits (digit0 always shown).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DATA_W   = 14,     // <= 14
  parameter int SCAN_DIV = 50000   // cycles per digit, >= 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              ovf,
  output logic [3:0]        com,
  output logic [6:0]        data_out
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  // Refresh scanning
  logic [CNT_W-1:0] r_div_cnt;
  logic [1:0]       r_digit_idx;
  logic             w_tick;

  // Conversion datapath
  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_sr, w_sr_nxt;
  logic [15:0]       r_acc, w_acc_nxt, w_acc_adj;
  logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic              r_ovf_pend, w_ovf_pend_nxt;
  logic [15:0]       r_disp_bcd, w_disp_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic              w_value_ovf;
  logic [DATA_W-1:0] w_clamped;

  // Display path
  logic [3:0] w_digit, w_dec_in;
  logic [6:0] w_seg;
  logic [3:0] r_com;
  logic [6:0] r_data_out;

  //--------------------------------------------------------------------------
  // Refresh prescaler and digit index
  //--------------------------------------------------------------------------
  assign w_tick = (r_div_cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div_cnt   <= '0;
      r_digit_idx <= 2'd0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + CNT_W'(1);
      if (w_tick) r_digit_idx <= r_digit_idx + 2'd1;
    end
  end

  //--------------------------------------------------------------------------
  // Conversion FSM
  //--------------------------------------------------------------------------
  assign w_value_ovf = (32'(value) > BCD_MAX);
  assign w_clamped   = w_value_ovf ? DATA_W'(BCD_MAX) : value;

  // Double-dabble correction: any nibble >= 5 would carry wrongly after the shift
  always_comb begin
    w_acc_adj = r_acc;
    for (int k = 0; k < 4; k++) begin
      if (r_acc[4*k +: 4] >= 4'd5) w_acc_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sr_nxt       = r_sr;
    w_acc_nxt      = r_acc;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_ovf_pend_nxt = r_ovf_pend;
    w_disp_nxt     = r_disp_bcd;
    w_ovf_nxt      = r_ovf;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_sr_nxt       = w_clamped;
          w_acc_nxt      = '0;
          w_bit_cnt_nxt  = '0;
          w_ovf_pend_nxt = w_value_ovf;
          w_state_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        w_acc_nxt     = {w_acc_adj[14:0], r_sr[DATA_W-1]};
        w_sr_nxt      = r_sr << 1;
        w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
        if (r_bit_cnt == BIT_W'(DATA_W - 1)) w_state_nxt = DONE;
      end
      DONE: begin
        // All four digits and ovf change in the same cycle, so the scan never tears
        w_disp_nxt  = r_acc;
        w_ovf_nxt   = r_ovf_pend;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sr       <= '0;
      r_acc      <= '0;
      r_bit_cnt  <= '0;
      r_ovf_pend <= 1'b0;
      r_disp_bcd <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_sr       <= w_sr_nxt;
      r_acc      <= w_acc_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_ovf_pend <= w_ovf_pend_nxt;
      r_disp_bcd <= w_disp_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Digit mux, optional leading-zero blanking, decode, output registers
  //--------------------------------------------------------------------------
  assign w_digit = r_disp_bcd[{r_digit_idx, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
  logic w_lz_blank;

  // Blank when this digit and everything above it is zero; digit0 is always shown
  always_comb begin
    w_lz_blank = (r_digit_idx != 2'd0);
    for (int k = 0; k < 4; k++) begin
      if ((k >= int'(r_digit_idx)) && (r_disp_bcd[4*k +: 4] != 4'd0)) w_lz_blank = 1'b0;
    end
  end

  // Code 15 decodes to a blank digit, so one decoder covers both cases
  assign w_dec_in = w_lz_blank ? 4'hF : w_digit;
`else
  assign w_dec_in = w_digit;
`endif

  seg7_bcd_decode u_dec (
    .i_bcd (w_dec_in),
    .o_seg (w_seg)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_com      <= COM_DIG0;
      r_data_out <= SEG_0;
    end else begin
      r_com      <= com_of(r_digit_idx);
      r_data_out <= w_seg;
    end
  end

  assign busy     = (r_state != IDLE);
  assign ovf      = r_ovf;
  assign com      = r_com;
  assign data_out = r_data_out;

endmodule
